adxl_spi_master: RTL and testbench

Single-register SPI master for the ADXL345 accelerometer, mode 3 (CPOL=1, CPHA=1), 16-bit frames. It sits directly downstream of `clkdiv`: `clkdiv`'s `clk_div` output drives `sclk_ref`, and each edge of that signal is one SPI half-period. All logic runs on the system clock. `sclk_ref` is only edge-detected, never used as a clock. The accelerometer control FSM drives `start` and reads back `rdata`.

---
 rtl/adxl_spi_master_if.sv | 14 +
 rtl/adxl_spi_master.sv | 115 +++++++++++
 tb/tb_adxl_spi_master.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adxl_spi_master_if.sv
// Control-side handshake between the accelerometer FSM and the SPI master.
// master = requesting FSM, slave = adxl_spi_master.
interface adxl_spi_master_if;
    logic       start;
    logic       rw;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;

    modport master (output start, rw, addr, wdata, input busy, done, rdata);
    modport slave  (input start, rw, addr, wdata, output busy, done, rdata);
endinterface

// File: rtl/adxl_spi_master.sv
// Single-register SPI mode-3 master for the ADXL345, 16-bit frames.
// sclk_ref is edge-detected on clk_i; each edge is one SPI half-period.
module adxl_spi_master #(
    parameter int unsigned CsGapTicks = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               sclk_ref_i,
    adxl_spi_master_if.slave   ctrl,
    output logic               spi_cs_n_o,
    output logic               spi_sclk_o,
    output logic               spi_mosi_o,
    input  logic               spi_miso_i
);
    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

    localparam logic [3:0] GapInit = 4'(CsGapTicks);

    state_e      state_q;
    logic        ref_q;
    logic        tick;
    logic [15:0] tx_q;
    logic [7:0]  rx_q;
    logic [3:0]  bit_cnt_q;
    logic [3:0]  gap_cnt_q;
    logic        rw_q;
    logic        cs_n_q;
    logic        sclk_q;
    logic        mosi_q;
    logic        busy_q;
    logic        done_q;
    logic [7:0]  rdata_q;

    assign tick = sclk_ref_i ^ ref_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            ref_q     <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            rw_q      <= 1'b0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            ref_q  <= sclk_ref_i;
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // A tick coinciding with acceptance is deliberately not counted.
                    if (ctrl.start) begin
                        rw_q      <= ctrl.rw;
                        tx_q      <= {ctrl.rw, 1'b0, ctrl.addr, ctrl.rw ? 8'h00 : ctrl.wdata};
                        bit_cnt_q <= '0;
                        cs_n_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= StSetup;
                    end
                end
                StSetup: begin
                    if (tick) state_q <= StShift;
                end
                StShift: begin
                    if (tick) begin
                        if (sclk_q) begin
                            sclk_q <= 1'b0;
                            mosi_q <= tx_q[15];
                        end else begin
                            sclk_q    <= 1'b1;
                            rx_q      <= {rx_q[6:0], spi_miso_i};
                            tx_q      <= {tx_q[14:0], 1'b0};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd15) state_q <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (tick) begin
                        cs_n_q    <= 1'b1;
                        mosi_q    <= 1'b0;
                        done_q    <= 1'b1;
                        if (rw_q) rdata_q <= rx_q;
                        gap_cnt_q <= GapInit;
                        state_q   <= StGap;
                    end
                end
                StGap: begin
                    if (tick) begin
                        if (gap_cnt_q <= 4'd1) begin
                            gap_cnt_q <= '0;
                            busy_q    <= 1'b0;
                            state_q   <= StIdle;
                        end else begin
                            gap_cnt_q <= gap_cnt_q - 4'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ctrl.busy  = busy_q;
    assign ctrl.done  = done_q;
    assign ctrl.rdata = rdata_q;
    assign spi_cs_n_o = cs_n_q;
    assign spi_sclk_o = sclk_q;
    assign spi_mosi_o = mosi_q;
endmodule

// File: tb/tb_adxl_spi_master.sv
// Directed bench for adxl_spi_master: mode-3 slave model plus per-scenario tasks.
module tb_adxl_spi_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk_ref = 1'b0;
    logic ref_run = 1'b1;
    logic [1:0] div = 2'd0;
    logic ref_m;
    logic spi_cs_n, spi_sclk, spi_mosi;
    logic spi_miso = 1'b1;

    adxl_spi_master_if bus ();

    adxl_spi_master #(.CsGapTicks(2)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .sclk_ref_i (sclk_ref),
        .ctrl       (bus),
        .spi_cs_n_o (spi_cs_n),
        .spi_sclk_o (spi_sclk),
        .spi_mosi_o (spi_mosi),
        .spi_miso_i (spi_miso)
    );

    always #10 clk = ~clk;

    // sclk_ref toggles every 4 clk while ref_run is high
    always @(posedge clk) begin
        if (ref_run) begin
            if (div == 2'd3) begin
                div      <= 2'd0;
                sclk_ref <= ~sclk_ref;
            end else begin
                div <= div + 2'd1;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ref_m <= 1'b0;
        else        ref_m <= sclk_ref;
    end

    wire tick_pend = sclk_ref ^ ref_m;

    int total = 0;
    int bad = 0;
    logic [7:0] slave_resp = 8'h00;

    // Monitor and slave model, sampled on the falling clk edge
    logic        sclk_prev = 1'b1, cs_prev = 1'b1, busy_prev = 1'b0, mosi_prev = 1'b0;
    logic [15:0] sreg = 16'h0000;
    logic [15:0] mosi_cap = 16'h0000;
    int cyc = 0, falls = 0, dones = 0, cs_falls = 0, cs_low_clk = 0, cs_ticks = 0;
    int mosi_bad = 0, busy_fall_cyc = 0, cs_fall_cyc = 0;

    always @(negedge clk) begin
        cyc       <= cyc + 1;
        sclk_prev <= spi_sclk;
        cs_prev   <= spi_cs_n;
        busy_prev <= bus.busy;
        mosi_prev <= spi_mosi;
        if (sclk_prev && !spi_sclk) begin
            falls    <= falls + 1;
            spi_miso <= sreg[15];
            sreg     <= {sreg[14:0], 1'b0};
        end
        if (cs_prev && !spi_cs_n) begin
            sreg        <= {8'h00, slave_resp};
            cs_falls    <= cs_falls + 1;
            cs_fall_cyc <= cyc;
        end
        if (!sclk_prev && spi_sclk && !spi_cs_n) mosi_cap <= {mosi_cap[14:0], spi_mosi};
        if (spi_mosi !== mosi_prev && !(sclk_prev && !spi_sclk) && !(!cs_prev && spi_cs_n))
            mosi_bad <= mosi_bad + 1;
        if (bus.done) dones <= dones + 1;
        if (!spi_cs_n) cs_low_clk <= cs_low_clk + 1;
        if (!spi_cs_n && tick_pend) cs_ticks <= cs_ticks + 1;
        if (busy_prev && !bus.busy) busy_fall_cyc <= cyc;
    end

    task automatic set_req(input logic rw, input logic [5:0] addr, input logic [7:0] wdata);
        bus.rw    = rw;
        bus.addr  = addr;
        bus.wdata = wdata;
    endtask

    // Pulse start so that acceptance coincides with a tick
    task automatic pulse_start(input logic rw, input logic [5:0] addr, input logic [7:0] wdata);
        int n = 0;
        @(negedge clk); #1;
        while (!tick_pend && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        set_req(rw, addr, wdata);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(output bit timed_out);
        int n = 0;
        while (bus.busy === 1'b1 && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        timed_out = (bus.busy !== 1'b0);
    endtask

    task automatic wait_cs_ticks(input int base, input int num, output bit timed_out);
        int n = 0;
        while (cs_ticks - base < num && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        timed_out = (cs_ticks - base < num);
    endtask

    task automatic test_reset();
        total += 6;
        if (spi_cs_n !== 1'b1) begin bad++; $display("FAIL rst_cs_n got=%b exp=1", spi_cs_n); end
        if (spi_sclk !== 1'b1) begin bad++; $display("FAIL rst_sclk got=%b exp=1", spi_sclk); end
        if (spi_mosi !== 1'b0) begin bad++; $display("FAIL rst_mosi got=%b exp=0", spi_mosi); end
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", bus.done); end
        if (bus.rdata !== 8'h00) begin bad++; $display("FAIL rst_rdata got=%h exp=00", bus.rdata); end
    endtask

    task automatic test_read();
        int f0 = falls, d0 = dones, l0 = cs_low_clk, t0 = cs_ticks, m0 = mosi_bad;
        bit to;
        slave_resp = 8'hE5;
        pulse_start(1'b1, 6'h00, 8'hAA);
        wait_idle(to);
        total += 9;
        if (to) begin bad++; $display("FAIL read_timeout busy=%b exp=0", bus.busy); end
        if (mosi_cap !== 16'h8000) begin bad++; $display("FAIL read_mosi got=%h exp=8000", mosi_cap); end
        if (falls - f0 != 16) begin bad++; $display("FAIL read_falls got=%0d exp=16", falls - f0); end
        if (dones - d0 != 1) begin bad++; $display("FAIL read_dones got=%0d exp=1", dones - d0); end
        if (bus.rdata !== 8'hE5) begin bad++; $display("FAIL read_rdata got=%h exp=e5", bus.rdata); end
        if (cs_ticks - t0 != 34) begin bad++; $display("FAIL read_cs_ticks got=%0d exp=34", cs_ticks - t0); end
        if (cs_low_clk - l0 != 136) begin bad++; $display("FAIL read_cs_clk got=%0d exp=136", cs_low_clk - l0); end
        if (spi_sclk !== 1'b1) begin bad++; $display("FAIL read_sclk_idle got=%b exp=1", spi_sclk); end
        if (mosi_bad != m0) begin bad++; $display("FAIL read_mosi_edge got=%0d exp=%0d", mosi_bad, m0); end
    endtask

    task automatic test_write();
        int n = 0, gap = 0;
        bit to;
        slave_resp = 8'h3C;
        pulse_start(1'b0, 6'h2D, 8'h08);
        while (bus.done !== 1'b1 && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        total += 2;
        if (bus.done !== 1'b1) begin bad++; $display("FAIL write_done_timeout got=%b exp=1", bus.done); end
        if (bus.rdata !== 8'hE5) begin bad++; $display("FAIL write_rdata got=%h exp=e5", bus.rdata); end
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            if (tick_pend) gap++;
            @(negedge clk); #1;
            n++;
        end
        wait_idle(to);
        total += 3;
        if (to) begin bad++; $display("FAIL write_timeout busy=%b exp=0", bus.busy); end
        if (gap != 2) begin bad++; $display("FAIL write_gap_ticks got=%0d exp=2", gap); end
        if (mosi_cap !== 16'h2D08) begin bad++; $display("FAIL write_mosi got=%h exp=2d08", mosi_cap); end
    endtask

    task automatic test_start_while_busy();
        int d0 = dones, c0 = cs_falls, t0 = cs_ticks;
        bit to;
        pulse_start(1'b0, 6'h2D, 8'h55);
        wait_cs_ticks(t0, 10, to);
        set_req(1'b1, 6'h3F, 8'hFF);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_idle(to);
        repeat (60) @(negedge clk);
        #1;
        total += 5;
        if (to) begin bad++; $display("FAIL swb_timeout busy=%b exp=0", bus.busy); end
        if (mosi_cap !== 16'h2D55) begin bad++; $display("FAIL swb_mosi got=%h exp=2d55", mosi_cap); end
        if (dones - d0 != 1) begin bad++; $display("FAIL swb_dones got=%0d exp=1", dones - d0); end
        if (cs_falls - c0 != 1) begin bad++; $display("FAIL swb_frames got=%0d exp=1", cs_falls - c0); end
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL swb_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_reset_mid_frame();
        int d0, t0 = cs_ticks;
        bit to;
        slave_resp = 8'h77;
        pulse_start(1'b1, 6'h00, 8'h00);
        wait_cs_ticks(t0, 20, to);
        d0 = dones;
        rst_n = 1'b0;
        #1;
        total += 7;
        if (to) begin bad++; $display("FAIL rmid_tick_timeout got=%0d exp=20", cs_ticks - t0); end
        if (spi_cs_n !== 1'b1) begin bad++; $display("FAIL rmid_cs_n got=%b exp=1", spi_cs_n); end
        if (spi_sclk !== 1'b1) begin bad++; $display("FAIL rmid_sclk got=%b exp=1", spi_sclk); end
        if (spi_mosi !== 1'b0) begin bad++; $display("FAIL rmid_mosi got=%b exp=0", spi_mosi); end
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", bus.busy); end
        if (bus.done !== 1'b0) begin bad++; $display("FAIL rmid_done got=%b exp=0", bus.done); end
        if (bus.rdata !== 8'h00) begin bad++; $display("FAIL rmid_rdata got=%h exp=00", bus.rdata); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        total++;
        if (dones != d0) begin bad++; $display("FAIL rmid_no_done got=%0d exp=%0d", dones, d0); end
        d0 = dones;
        slave_resp = 8'h5A;
        pulse_start(1'b1, 6'h00, 8'h00);
        wait_idle(to);
        total += 4;
        if (to) begin bad++; $display("FAIL rmid_read_timeout busy=%b exp=0", bus.busy); end
        if (bus.rdata !== 8'h5A) begin bad++; $display("FAIL rmid_read_rdata got=%h exp=5a", bus.rdata); end
        if (mosi_cap !== 16'h8000) begin bad++; $display("FAIL rmid_read_mosi got=%h exp=8000", mosi_cap); end
        if (dones - d0 != 1) begin bad++; $display("FAIL rmid_read_dones got=%0d exp=1", dones - d0); end
    endtask

    task automatic test_stall();
        int t0 = cs_ticks, f0 = falls, moved = 0;
        logic [4:0] snap;
        bit to;
        slave_resp = 8'hA7;
        pulse_start(1'b1, 6'h32, 8'h00);
        wait_cs_ticks(t0, 5, to);
        ref_run = 1'b0;
        @(negedge clk); #1;
        snap = {spi_cs_n, spi_sclk, spi_mosi, bus.busy, bus.done};
        repeat (99) begin
            @(negedge clk); #1;
            if ({spi_cs_n, spi_sclk, spi_mosi, bus.busy, bus.done} !== snap) moved++;
        end
        ref_run = 1'b1;
        wait_idle(to);
        total += 6;
        if (moved != 0) begin bad++; $display("FAIL stall_static got=%0d exp=0", moved); end
        if (to) begin bad++; $display("FAIL stall_timeout busy=%b exp=0", bus.busy); end
        if (bus.rdata !== 8'hA7) begin bad++; $display("FAIL stall_rdata got=%h exp=a7", bus.rdata); end
        if (mosi_cap !== 16'hB200) begin bad++; $display("FAIL stall_mosi got=%h exp=b200", mosi_cap); end
        if (cs_ticks - t0 != 34) begin bad++; $display("FAIL stall_cs_ticks got=%0d exp=34", cs_ticks - t0); end
        if (falls - f0 != 16) begin bad++; $display("FAIL stall_falls got=%0d exp=16", falls - f0); end
    endtask

    task automatic test_back_to_back();
        int d0 = dones, c0 = cs_falls, n = 0, gap = 0;
        bit to;
        set_req(1'b0, 6'h31, 8'h0B);
        @(negedge clk); #1;
        bus.start = 1'b1;
        while (dones == d0 && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        n = 0;
        while (spi_cs_n === 1'b1 && n < 200) begin
            if (tick_pend) gap++;
            @(negedge clk); #1;
            n++;
        end
        bus.start = 1'b0;
        @(negedge clk); #1;
        total += 3;
        if (cs_falls - c0 != 2) begin bad++; $display("FAIL b2b_second_fall got=%0d exp=2", cs_falls - c0); end
        if (cs_fall_cyc - busy_fall_cyc != 1) begin
            bad++;
            $display("FAIL b2b_restart_lat got=%0d exp=1", cs_fall_cyc - busy_fall_cyc);
        end
        if (gap < 2) begin bad++; $display("FAIL b2b_gap_ticks got=%0d exp>=2", gap); end
        wait_idle(to);
        repeat (40) @(negedge clk);
        #1;
        total += 4;
        if (to) begin bad++; $display("FAIL b2b_timeout busy=%b exp=0", bus.busy); end
        if (dones - d0 != 2) begin bad++; $display("FAIL b2b_dones got=%0d exp=2", dones - d0); end
        if (mosi_cap !== 16'h310B) begin bad++; $display("FAIL b2b_mosi got=%h exp=310b", mosi_cap); end
        if (cs_falls - c0 != 2) begin bad++; $display("FAIL b2b_frames got=%0d exp=2", cs_falls - c0); end
    endtask

    initial begin
        bus.start = 1'b0;
        set_req(1'b0, 6'h00, 8'h00);
        repeat (5) @(negedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        test_read();
        test_write();
        test_start_while_busy();
        test_reset_mid_frame();
        test_stall();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
